// File: rtl/tft_bus_decoder_pkg.sv
// Shared TFT bus definitions: opcodes, ID bytes, decoder state, payload structs.
package tft_bus_decoder_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned COORD_W  = 16;
  localparam int unsigned COLOR_W  = 16;
  localparam int unsigned RD_IDX_W = 3;

  localparam logic [BYTE_W-1:0] CMD_CASET = 8'h2A;
  localparam logic [BYTE_W-1:0] CMD_PASET = 8'h2B;
  localparam logic [BYTE_W-1:0] CMD_RAMWR = 8'h2C;
  localparam logic [BYTE_W-1:0] CMD_RDID  = 8'hD3;

  localparam logic [BYTE_W-1:0] ID_BYTE2 = 8'h93;
  localparam logic [BYTE_W-1:0] ID_BYTE3 = 8'h41;
  localparam logic [RD_IDX_W-1:0] RD_IDX_DONE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR_HI,
    ST_RAMWR_LO
  } dec_state_e;

  // Raw host bus sample; field order matches the synchronizer input concatenation
  typedef struct packed {
    logic              cs;
    logic              rs;
    logic              wr;
    logic              rd;
    logic              rst;
    logic [BYTE_W-1:0] data;
  } bus_sample_t;

  localparam bus_sample_t BUS_IDLE = '{cs: 1'b1, rs: 1'b0, wr: 1'b1, rd: 1'b1,
                                       rst: 1'b1, data: 8'h00};

  typedef struct packed {
    dec_state_e          state;
    logic [1:0]          pcnt;
    logic [COORD_W-1:0]  pstart;
    logic [BYTE_W-1:0]   pend_hi;
    logic [BYTE_W-1:0]   color_hi;
    logic [COORD_W-1:0]  xs;
    logic [COORD_W-1:0]  xe;
    logic [COORD_W-1:0]  ys;
    logic [COORD_W-1:0]  ye;
    logic [COORD_W-1:0]  cx;
    logic [COORD_W-1:0]  cy;
    logic [RD_IDX_W-1:0] rd_idx;
  } dec_ctx_t;

  typedef struct packed {
    logic [BYTE_W-1:0]  rd_data;
    logic               cmd_valid;
    logic [BYTE_W-1:0]  cmd_byte;
    logic               pix_valid;
    logic [BYTE_W-1:0]  pix_x;
    logic [BYTE_W-1:0]  pix_y;
    logic [COLOR_W-1:0] pix_color;
  } dec_out_t;

  // Panel ID read-back sequence
  function automatic logic [BYTE_W-1:0] id_byte(input logic [RD_IDX_W-1:0] idx);
    case (idx)
      3'd2:    return ID_BYTE2;
      3'd3:    return ID_BYTE3;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/tft_bus_sync.sv
// Bus synchronizer with write/read strobe rising-edge detection.
module tft_bus_sync
  import tft_bus_decoder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  bus_sample_t       bus,
  output logic              rst_sync,
  output logic              byte_evt,
  output logic              evt_rs,
  output logic [BYTE_W-1:0] evt_data,
  output logic              rd_rise,
  output logic              rd_oe
);

  bus_sample_t stage [SYNC_STAGES];
  bus_sample_t sync;
  logic        wr_prev;
  logic        rd_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) stage[i] <= BUS_IDLE;
    end else begin
      stage[0] <= bus;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign sync     = stage[SYNC_STAGES-1];
  assign rst_sync = sync.rst;

  // Previous-strobe flops reset high so reset release never looks like an edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_prev  <= 1'b1;
      rd_prev  <= 1'b1;
      byte_evt <= 1'b0;
      evt_rs   <= 1'b0;
      evt_data <= '0;
      rd_rise  <= 1'b0;
      rd_oe    <= 1'b0;
    end else begin
      wr_prev  <= sync.wr;
      rd_prev  <= sync.rd;
      byte_evt <= !wr_prev && sync.wr && !sync.cs;
      evt_rs   <= sync.rs;
      evt_data <= sync.data;
      rd_rise  <= !rd_prev && sync.rd && !sync.cs;
      rd_oe    <= !stage[SYNC_STAGES-2].cs && !stage[SYNC_STAGES-2].rd;
    end
  end

endmodule

// File: rtl/tft_bus_decoder.sv
// 8080-style TFT host bus decoder: window/cursor tracking and RGB565 pixel output.
module tft_bus_decoder
  import tft_bus_decoder_pkg::*;
#(
  parameter int unsigned WIDTH       = 160,
  parameter int unsigned HEIGHT      = 144,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tft_rst,
  input  logic        tft_cs,
  input  logic        tft_rs,
  input  logic        tft_wr,
  input  logic        tft_rd,
  input  logic [7:0]  tft_data,
  output logic [7:0]  rd_data,
  output logic        rd_oe,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        pix_valid,
  output logic [7:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic [15:0] pix_color
);

  localparam logic [COORD_W-1:0] WIDTH_C  = COORD_W'(WIDTH);
  localparam logic [COORD_W-1:0] HEIGHT_C = COORD_W'(HEIGHT);
  localparam dec_ctx_t CTX_RST = '{state: ST_IDLE, pcnt: 2'd0, pstart: '0, pend_hi: '0,
                                   color_hi: '0, xs: '0, xe: COORD_W'(WIDTH - 1),
                                   ys: '0, ye: COORD_W'(HEIGHT - 1), cx: '0, cy: '0,
                                   rd_idx: RD_IDX_DONE};

  bus_sample_t        bus_in;
  logic               rst_sync;
  logic               byte_evt;
  logic               evt_rs;
  logic [BYTE_W-1:0]  evt_data;
  logic               rd_rise;
  dec_ctx_t           ctx_q, ctx_d;
  dec_out_t           out_q, out_d;
  logic [COORD_W-1:0] win_end;
  logic [COORD_W-1:0] win_end_clamped;

  assign bus_in = {tft_cs, tft_rs, tft_wr, tft_rd, tft_rst, tft_data};

  tft_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus_in),
    .rst_sync (rst_sync),
    .byte_evt (byte_evt),
    .evt_rs   (evt_rs),
    .evt_data (evt_data),
    .rd_rise  (rd_rise),
    .rd_oe    (rd_oe)
  );

  // Panel reset from the host bus behaves like reset_n, but synchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctx_q <= CTX_RST;
      out_q <= '0;
    end else if (!rst_sync) begin
      ctx_q <= CTX_RST;
      out_q <= '0;
    end else begin
      ctx_q <= ctx_d;
      out_q <= out_d;
    end
  end

  always_comb begin
    ctx_d           = ctx_q;
    out_d           = out_q;
    out_d.cmd_valid = 1'b0;
    out_d.pix_valid = 1'b0;
    win_end         = {ctx_q.pend_hi, evt_data};
    win_end_clamped = (win_end < ctx_q.pstart) ? ctx_q.pstart : win_end;

    if (rd_rise && ctx_q.rd_idx < RD_IDX_DONE) ctx_d.rd_idx = ctx_q.rd_idx + 3'd1;

    if (byte_evt && !evt_rs) begin
      // Any command aborts the current sequence and its partial state
      ctx_d.pcnt = 2'd0;
      case (evt_data)
        CMD_CASET: ctx_d.state = ST_CASET;
        CMD_PASET: ctx_d.state = ST_PASET;
        CMD_RAMWR: begin
          ctx_d.state = ST_RAMWR_HI;
          ctx_d.cx    = ctx_q.xs;
          ctx_d.cy    = ctx_q.ys;
        end
        CMD_RDID: begin
          ctx_d.state  = ST_IDLE;
          ctx_d.rd_idx = '0;
        end
        default: begin
          ctx_d.state     = ST_IDLE;
          out_d.cmd_valid = 1'b1;
          out_d.cmd_byte  = evt_data;
        end
      endcase
    end else if (byte_evt) begin
      case (ctx_q.state)
        ST_CASET, ST_PASET: begin
          ctx_d.pcnt = ctx_q.pcnt + 2'd1;
          case (ctx_q.pcnt)
            2'd0: ctx_d.pstart[15:8] = evt_data;
            2'd1: ctx_d.pstart[7:0]  = evt_data;
            2'd2: ctx_d.pend_hi      = evt_data;
            default: begin
              if (ctx_q.state == ST_CASET) begin
                ctx_d.xs = ctx_q.pstart;
                ctx_d.xe = win_end_clamped;
              end else begin
                ctx_d.ys = ctx_q.pstart;
                ctx_d.ye = win_end_clamped;
              end
              ctx_d.state = ST_IDLE;
            end
          endcase
        end
        ST_RAMWR_HI: begin
          ctx_d.color_hi = evt_data;
          ctx_d.state    = ST_RAMWR_LO;
        end
        ST_RAMWR_LO: begin
          ctx_d.state     = ST_RAMWR_HI;
          out_d.pix_valid = (ctx_q.cx < WIDTH_C) && (ctx_q.cy < HEIGHT_C);
          out_d.pix_x     = ctx_q.cx[7:0];
          out_d.pix_y     = ctx_q.cy[7:0];
          out_d.pix_color = {ctx_q.color_hi, evt_data};
          if (ctx_q.cx < ctx_q.xe) begin
            ctx_d.cx = ctx_q.cx + 16'd1;
          end else begin
            ctx_d.cx = ctx_q.xs;
            ctx_d.cy = (ctx_q.cy < ctx_q.ye) ? ctx_q.cy + 16'd1 : ctx_q.ys;
          end
        end
        default: ;
      endcase
    end

    out_d.rd_data = id_byte(ctx_d.rd_idx);
  end

  assign rd_data   = out_q.rd_data;
  assign cmd_valid = out_q.cmd_valid;
  assign cmd_byte  = out_q.cmd_byte;
  assign pix_valid = out_q.pix_valid;
  assign pix_x     = out_q.pix_x;
  assign pix_y     = out_q.pix_y;
  assign pix_color = out_q.pix_color;

endmodule

// File: tb/tb_tft_bus_decoder.sv
// Scoreboard bench for tft_bus_decoder: directed bus transactions, queued expectations.
module tb_tft_bus_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tft_rst, tft_cs, tft_rs, tft_wr, tft_rd;
  logic [7:0]  tft_data;
  logic [7:0]  rd_data;
  logic        rd_oe;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        pix_valid;
  logic [7:0]  pix_x, pix_y;
  logic [15:0] pix_color;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] pix_q[$];
  logic [7:0]  cmd_q[$];
  logic [7:0]  rd_q[$];
  logic        rd_seen = 1'b0;
  logic [7:0]  rd_last = 8'h00;

  tft_bus_decoder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tft_rst   (tft_rst),
    .tft_cs    (tft_cs),
    .tft_rs    (tft_rs),
    .tft_wr    (tft_wr),
    .tft_rd    (tft_rd),
    .tft_data  (tft_data),
    .rd_data   (rd_data),
    .rd_oe     (rd_oe),
    .cmd_valid (cmd_valid),
    .cmd_byte  (cmd_byte),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] d);
    @(negedge clk);
    tft_cs = 1'b0; tft_rs = rs; tft_data = d; tft_wr = 1'b0;
    repeat (3) @(negedge clk);
    tft_wr = 1'b1;
    repeat (3) @(negedge clk);
    tft_cs = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] d);
    bus_write(1'b0, d);
  endtask

  task automatic dat(input logic [7:0] d);
    bus_write(1'b1, d);
  endtask

  task automatic window(input logic [7:0] op, input logic [15:0] s, input logic [15:0] e);
    cmd(op);
    dat(s[15:8]); dat(s[7:0]); dat(e[15:8]); dat(e[7:0]);
  endtask

  // Sends one pixel; pushes an expectation only when it should be visible
  task automatic pixel(input logic [15:0] c, input bit vis, input logic [7:0] x,
                       input logic [7:0] y);
    if (vis) pix_q.push_back({x, y, c});
    dat(c[15:8]);
    dat(c[7:0]);
  endtask

  task automatic bus_read(input logic [7:0] exp);
    rd_q.push_back(exp);
    @(negedge clk);
    tft_cs = 1'b0; tft_rd = 1'b0;
    repeat (4) @(negedge clk);
    tft_rd = 1'b1;
    repeat (3) @(negedge clk);
    tft_cs = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Monitor: compare every presented output against the head of its queue
  always @(negedge clk) begin
    if (reset_n) begin
      if (pix_valid) begin
        if (pix_q.size() == 0) begin
          chk("pix_unexpected", {pix_x, pix_y, pix_color}, 32'h0);
        end else begin
          logic [31:0] e;
          e = pix_q.pop_front();
          chk("pix_x", 32'(pix_x), 32'(e[31:24]));
          chk("pix_y", 32'(pix_y), 32'(e[23:16]));
          chk("pix_color", 32'(pix_color), 32'(e[15:0]));
        end
      end
      if (cmd_valid) begin
        if (cmd_q.size() == 0) chk("cmd_unexpected", 32'(cmd_byte), 32'hFFFF_FFFF);
        else chk("cmd_byte", 32'(cmd_byte), 32'(cmd_q.pop_front()));
      end
      if (rd_oe) begin
        rd_seen = 1'b1;
        rd_last = rd_data;
      end else if (rd_seen) begin
        rd_seen = 1'b0;
        if (rd_q.size() == 0) chk("rd_unexpected", 32'(rd_last), 32'hFFFF_FFFF);
        else chk("rd_data", 32'(rd_last), 32'(rd_q.pop_front()));
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    tft_rst = 1'b1; tft_cs = 1'b1; tft_rs = 1'b0; tft_wr = 1'b1; tft_rd = 1'b1;
    tft_data = 8'h00;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    chk("rst_pix_valid", 32'(pix_valid), 32'h0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'h0);
    chk("rst_rd_oe", 32'(rd_oe), 32'h0);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    chk("rst_pix_color", 32'(pix_color), 32'h0);
    chk("rst_pix_xy", 32'({pix_x, pix_y}), 32'h0);

    // First pixel after reset lands at the origin
    cmd(8'h2C);
    pixel(16'hF800, 1'b1, 8'd0, 8'd0);

    // 3x2 window, 7 pixels wrap back to window start
    window(8'h2A, 16'd10, 16'd12);
    window(8'h2B, 16'd5, 16'd6);
    cmd(8'h2C);
    for (int i = 0; i < 7; i++)
      pixel(16'hA000 + 16'(i), 1'b1, 8'(10 + i % 3), 8'(5 + (i / 3) % 2));

    // Pending high byte discarded by a new RAMWR
    cmd(8'h2C);
    dat(8'h12);
    cmd(8'h2C);
    pixel(16'h3456, 1'b1, 8'd10, 8'd5);

    // Off-screen window: nothing visible, cursor still wraps
    window(8'h2A, 16'd200, 16'd201);
    cmd(8'h2C);
    for (int i = 0; i < 4; i++) pixel(16'h0F00 + 16'(i), 1'b0, 8'd0, 8'd0);

    // end < start clamps to a one-column window
    window(8'h2A, 16'd20, 16'd5);
    cmd(8'h2C);
    pixel(16'h1111, 1'b1, 8'd20, 8'd5);
    pixel(16'h2222, 1'b1, 8'd20, 8'd6);
    pixel(16'h3333, 1'b1, 8'd20, 8'd5);

    // ID read-back
    cmd(8'hD3);
    bus_read(8'h00); bus_read(8'h00); bus_read(8'h93); bus_read(8'h41); bus_read(8'h00);

    // Unhandled command, then ignored idle data
    cmd_q.push_back(8'h11);
    cmd(8'h11);
    dat(8'h55);

    // Panel reset mid-CASET restores full-screen window
    cmd(8'h2A);
    dat(8'h00); dat(8'h03);
    tft_rst = 1'b0;
    repeat (6) @(negedge clk);
    tft_rst = 1'b1;
    repeat (4) @(negedge clk);
    cmd(8'h2C);
    for (int i = 0; i < 161; i++)
      pixel(16'(i) ^ 16'h5A5A, 1'b1, 8'(i % 160), 8'(i / 160));

    for (int i = 0; i < 100; i++) begin
      if (pix_q.size() == 0 && cmd_q.size() == 0 && rd_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_pix", 32'(pix_q.size()), 32'h0);
    chk("drain_cmd", 32'(cmd_q.size()), 32'h0);
    chk("drain_rd", 32'(rd_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
